// File: rtl/fft_r22sdf_bfi_stage_pkg.sv
// Shared helpers for the R2^2 SDF butterfly stages: clog2, width derivation and round-half-up.
// Output width and rounding depend on the FFT_BFI_SCALE_EN macro.
package fft_r22sdf_bfi_stage_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Internal datapath width: one guard bit so x +/- xsr never overflows.
  function automatic int unsigned w1(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned out_width(input int unsigned dw);
`ifdef FFT_BFI_SCALE_EN
    return dw;
`else
    return dw + 1;
`endif
  endfunction

  // (v + 1) >>> 1 on a wide container; callers truncate to their output width.
  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v);
    return (v + 64'sd1) >>> 1;
  endfunction

endpackage

// File: rtl/fft_bfi_delay.sv
// Valid-gated LEN-deep delay: q_o is the d_i accepted LEN enabled beats earlier.
// Short delays use a register chain, long ones a circular memory with a single pointer.
module fft_bfi_delay
  import fft_r22sdf_bfi_stage_pkg::*;
#(
  parameter int unsigned WIDTH      = 26,
  parameter int unsigned LEN        = 512,
  parameter int unsigned SRL_THRESH = 32
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (LEN <= SRL_THRESH) begin : g_chain
    logic [WIDTH-1:0] sr [LEN];

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        sr[0] <= d_i;
        for (int unsigned i = 1; i < LEN; i++) sr[i] <= sr[i-1];
      end
    end

    assign q_o = sr[LEN-1];
  end else begin : g_ram
    localparam int unsigned PW = (LEN > 1) ? clog2(LEN) : 1;

    logic [WIDTH-1:0] mem [LEN];
    logic [PW-1:0]    ptr;

    // Read-before-write at the same slot gives exactly LEN beats of delay; any start pointer works.
    always_ff @(posedge clk_i) begin
      if (en_i) begin
        mem[ptr] <= d_i;
        ptr      <= (ptr == PW'(LEN - 1)) ? '0 : ptr + PW'(1);
      end
    end

    assign q_o = mem[ptr];
  end

endmodule

// File: rtl/fft_r22sdf_bfi_stage.sv
// Self-sequenced R2^2 SDF butterfly-I stage with valid-gated feedback delay and frame sync.
// Define FFT_BFI_SCALE_EN to halve outputs with round-half-up (OUT_WIDTH = DATA_WIDTH).
module fft_r22sdf_bfi_stage
  import fft_r22sdf_bfi_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 25,
  parameter int unsigned SHIFT_REG_LEN = 512,
  parameter int unsigned SRL_THRESH    = 32,
  localparam int unsigned OUT_WIDTH    = out_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  sync_i,
  input  logic [DATA_WIDTH-1:0] x_re_i,
  input  logic [DATA_WIDTH-1:0] x_im_i,
  output logic                  valid_o,
  output logic                  sel_o,
  output logic [OUT_WIDTH-1:0]  z_re_o,
  output logic [OUT_WIDTH-1:0]  z_im_o
);

  localparam int unsigned W1 = w1(DATA_WIDTH);
  localparam int unsigned LW = clog2(SHIFT_REG_LEN);
  localparam int unsigned CW = LW + 1;

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_eff;
  logic                 primed;
  logic                 sync_q;
  logic                 resync;
  logic                 sel;
  logic signed [W1-1:0] x_re, x_im;
  logic signed [W1-1:0] xsr_re, xsr_im;
  logic signed [W1-1:0] d_re, d_im;
  logic signed [W1-1:0] v_re, v_im;

  // A sync landing on the natural wrap (cnt==0) must not disturb priming.
  always_comb begin
    sync_q  = valid_i & sync_i;
    resync  = sync_q && (cnt != '0);
    cnt_eff = sync_q ? '0 : cnt;
    sel     = cnt_eff[LW];
    x_re    = {x_re_i[DATA_WIDTH-1], x_re_i};
    x_im    = {x_im_i[DATA_WIDTH-1], x_im_i};
    v_re    = xsr_re;
    v_im    = xsr_im;
    d_re    = x_re;
    d_im    = x_im;
    if (sel) begin
      v_re = x_re + xsr_re;
      v_im = x_im + xsr_im;
      d_re = xsr_re - x_re;
      d_im = xsr_im - x_im;
    end
  end

  fft_bfi_delay #(
    .WIDTH      (W1),
    .LEN        (SHIFT_REG_LEN),
    .SRL_THRESH (SRL_THRESH)
  ) u_dly_re (
    .clk_i (clk_i),
    .en_i  (valid_i),
    .d_i   (d_re),
    .q_o   (xsr_re)
  );

  fft_bfi_delay #(
    .WIDTH      (W1),
    .LEN        (SHIFT_REG_LEN),
    .SRL_THRESH (SRL_THRESH)
  ) u_dly_im (
    .clk_i (clk_i),
    .en_i  (valid_i),
    .d_i   (d_im),
    .q_o   (xsr_im)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      primed  <= 1'b0;
      valid_o <= 1'b0;
      sel_o   <= 1'b0;
      z_re_o  <= '0;
      z_im_o  <= '0;
    end else begin
      valid_o <= valid_i && ((primed && !resync) || sel);
      if (valid_i) begin
        cnt    <= cnt_eff + CW'(1);
        primed <= sel ? 1'b1 : (resync ? 1'b0 : primed);
        sel_o  <= sel;
`ifdef FFT_BFI_SCALE_EN
        z_re_o <= OUT_WIDTH'(round_half_up(64'(v_re)));
        z_im_o <= OUT_WIDTH'(round_half_up(64'(v_im)));
`else
        z_re_o <= v_re;
        z_im_o <= v_im;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fft_r22sdf_bfi_stage.sv
// Directed and model-based bench for fft_r22sdf_bfi_stage (L=2 table, L=64 RAM and L=16 chain streams).
// Honours FFT_BFI_SCALE_EN the same way as the design.
module tb_fft_r22sdf_bfi_stage;

  localparam int DW = 8;
`ifdef FFT_BFI_SCALE_EN
  localparam int OW = DW;
`else
  localparam int OW = DW + 1;
`endif
  localparam int NLONG = 576;

  logic clk = 1'b0;
  logic rst, valid, sync;
  logic [DW-1:0] x_re, x_im;
  logic valid_o, sel_o;
  logic signed [OW-1:0] z_re, z_im;

  logic lvalid, lsync;
  logic [DW-1:0] lx_re, lx_im;
  logic v64, s64, v16, s16;
  logic signed [OW-1:0] r64, i64, r16, i16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_r22sdf_bfi_stage #(.DATA_WIDTH(DW), .SHIFT_REG_LEN(2), .SRL_THRESH(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .sync_i(sync), .x_re_i(x_re), .x_im_i(x_im),
    .valid_o(valid_o), .sel_o(sel_o), .z_re_o(z_re), .z_im_o(z_im));

  fft_r22sdf_bfi_stage #(.DATA_WIDTH(DW), .SHIFT_REG_LEN(64), .SRL_THRESH(32)) dut64 (
    .clk_i(clk), .rst_i(rst), .valid_i(lvalid), .sync_i(lsync), .x_re_i(lx_re), .x_im_i(lx_im),
    .valid_o(v64), .sel_o(s64), .z_re_o(r64), .z_im_o(i64));

  fft_r22sdf_bfi_stage #(.DATA_WIDTH(DW), .SHIFT_REG_LEN(16), .SRL_THRESH(32)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(lvalid), .sync_i(lsync), .x_re_i(lx_re), .x_im_i(lx_im),
    .valid_o(v16), .sel_o(s16), .z_re_o(r16), .z_im_o(i16));

  typedef struct {
    logic r, v, s;
    int   re, im;
    logic ev, chk;
    int   zre, zim;
    logic zsel;
  } vec_t;

  vec_t tbl[$];

  int xr[NLONG];
  int xi[NLONG];
  int e_re[2][1024];
  int e_im[2][1024];
  int e_sel[2][1024];
  int wr[2];
  int rd[2];

  function automatic int scl(input int v);
`ifdef FFT_BFI_SCALE_EN
    return (v + 1) >>> 1;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic r, v, s, input int re, im, input logic ev, chkz,
                     input int zre, zim, input logic zsel);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.re = re; t.im = im;
    t.ev = ev; t.chk = chkz; t.zre = zre; t.zim = zim; t.zsel = zsel;
    tbl.push_back(t);
  endtask

  // Reference BF-I for a stream synced at beat 0: sums in the sel=1 half, previous frame's diffs in sel=0.
  task automatic model_push(input int d, input int L, input int i);
    int p;
    p = i % (2 * L);
    if (p >= L) begin
      e_re[d][wr[d]] = scl(xr[i] + xr[i-L]);
      e_im[d][wr[d]] = scl(xi[i] + xi[i-L]);
      e_sel[d][wr[d]] = 1;
      wr[d]++;
    end else if (i >= 2 * L) begin
      e_re[d][wr[d]] = scl(xr[i-2*L] - xr[i-L]);
      e_im[d][wr[d]] = scl(xi[i-2*L] - xi[i-L]);
      e_sel[d][wr[d]] = 0;
      wr[d]++;
    end
  endtask

  task automatic chk_long(input int d, input logic v, input logic s, input int re, input int im);
    string n;
    n = (d == 0) ? "L64" : "L16";
    if (v) begin
      if (rd[d] < wr[d]) begin
        chk($sformatf("%s out%0d re", n, rd[d]), re, e_re[d][rd[d]]);
        chk($sformatf("%s out%0d im", n, rd[d]), im, e_im[d][rd[d]]);
        chk($sformatf("%s out%0d sel", n, rd[d]), int'(s), e_sel[d][rd[d]]);
        rd[d]++;
      end else begin
        checks++;
        errors++;
        $display("FAIL %s unexpected valid_o: got 1 expected 0", n);
      end
    end
  endtask

  initial begin
    int gap, beat;
    int sre[9];
    int sim_[9];
    logic sev[9];

    rst = 1'b1; valid = 1'b0; sync = 1'b0; x_re = '0; x_im = '0;
    lvalid = 1'b0; lsync = 1'b0; lx_re = '0; lx_im = '0;
    wr[0] = 0; wr[1] = 0; rd[0] = 0; rd[1] = 0;

    //   r  v  s   re    im   ev chk  zre   zim  zsel
    add(1, 0, 0,    0,   0,  0, 1,    0,    0, 0);
    add(0, 1, 1,    1,  -1,  0, 0,    0,    0, 0);
    add(0, 1, 0,    2,  -2,  0, 0,    0,    0, 0);
    add(0, 1, 0,    3,  -3,  1, 1,    4,   -4, 1);
    add(0, 1, 0,    4,  -4,  1, 1,    6,   -6, 1);
    add(0, 1, 0,    5,  -5,  1, 1,   -2,    2, 0);
    add(0, 1, 0,    6,  -6,  1, 1,   -2,    2, 0);
    add(0, 1, 0,    7,  -7,  1, 1,   12,  -12, 1);
    add(0, 1, 0,    8,  -8,  1, 1,   14,  -14, 1);
    add(0, 1, 1,  127,   0,  1, 1,   -2,    2, 0);
    add(0, 1, 0,    0,   0,  1, 1,   -2,    2, 0);
    add(0, 1, 0,  127,   0,  1, 1,  254,    0, 1);
    add(0, 1, 0,    0,   0,  1, 1,    0,    0, 1);
    add(0, 1, 0, -128,   0,  1, 1,    0,    0, 0);
    add(0, 1, 0,    0,   0,  1, 1,    0,    0, 0);
    add(0, 1, 0, -128,   0,  1, 1, -256,    0, 1);
    add(0, 1, 0,    0,   0,  1, 1,    0,    0, 1);
    add(0, 1, 0,    1,   0,  1, 1,    0,    0, 0);
    add(0, 1, 0,    0,   0,  1, 1,    0,    0, 0);
    add(0, 1, 0,    2,   0,  1, 1,    3,    0, 1);
    add(0, 1, 0,    0,   0,  1, 1,    0,    0, 1);
    add(0, 1, 1,    1,   0,  1, 1,   -1,    0, 0);
    add(0, 1, 0,    2,   0,  1, 1,    0,    0, 0);
    add(0, 1, 0,    3,   0,  1, 1,    4,    0, 1);
    add(1, 0, 0,    0,   0,  0, 1,    0,    0, 0);
    add(0, 1, 1,    1,   0,  0, 0,    0,    0, 0);
    add(0, 1, 0,    2,   0,  0, 0,    0,    0, 0);
    add(0, 1, 0,    3,   0,  1, 1,    4,    0, 1);
    add(0, 1, 0,    4,   0,  1, 1,    6,    0, 1);
    add(0, 1, 0,    5,   0,  1, 1,   -2,    0, 0);
    add(0, 1, 0,    6,   0,  1, 1,   -2,    0, 0);
    add(0, 1, 0,    7,   0,  1, 1,   12,    0, 1);
    add(0, 1, 0,    8,   0,  1, 1,   14,    0, 1);
    add(0, 1, 0,    9,   0,  1, 1,   -2,    0, 0);
    add(0, 1, 1,   20,   0,  0, 0,    0,    0, 0);
    add(0, 1, 0,   21,   0,  0, 0,    0,    0, 0);
    add(0, 1, 0,   22,   0,  1, 1,   42,    0, 1);
    add(0, 1, 0,   23,   0,  1, 1,   44,    0, 1);
    add(0, 1, 0,   24,   0,  1, 1,   -2,    0, 0);
    add(0, 0, 0,    0,   0,  0, 1,   -2,    0, 0);

    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      rst = tbl[i].r; valid = tbl[i].v; sync = tbl[i].s;
      x_re = DW'(tbl[i].re); x_im = DW'(tbl[i].im);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d valid_o", i), int'(valid_o), int'(tbl[i].ev));
      if (tbl[i].chk) begin
        chk($sformatf("row%0d z_re", i), int'(z_re), scl(tbl[i].zre));
        chk($sformatf("row%0d z_im", i), int'(z_im), scl(tbl[i].zim));
        chk($sformatf("row%0d sel_o", i), int'(sel_o), int'(tbl[i].zsel));
      end
    end

    // Stalled basic frame: same values, one valid_o pulse per beat.
    sev = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
    sre = '{0, 0, 0, 4, 6, -2, -2, 12, 14};
    sim_ = '{0, 0, 0, -4, -6, 2, 2, -12, -14};
    rst = 1'b1; valid = 1'b0; sync = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int b = 1; b <= 8; b++) begin
      valid = 1'b1; sync = (b == 1); x_re = DW'(b); x_im = DW'(-b);
      @(posedge clk);
      #1;
      chk($sformatf("stall beat%0d valid_o", b), int'(valid_o), int'(sev[b]));
      if (sev[b]) begin
        chk($sformatf("stall beat%0d z_re", b), int'(z_re), scl(sre[b]));
        chk($sformatf("stall beat%0d z_im", b), int'(z_im), scl(sim_[b]));
      end
      gap = $urandom_range(1, 3);
      valid = 1'b0; sync = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        chk($sformatf("stall idle%0d.%0d valid_o", b, g), int'(valid_o), 0);
        if (sev[b]) chk($sformatf("stall idle%0d.%0d hold z_re", b, g), int'(z_re), scl(sre[b]));
      end
    end

    // Long random streams through the RAM (L=64) and register-chain (L=16) delays.
    for (int i = 0; i < NLONG; i++) begin
      xr[i] = int'($urandom_range(0, 255)) - 128;
      xi[i] = int'($urandom_range(0, 255)) - 128;
    end
    beat = 0;
    while (beat < NLONG) begin
      lvalid = ($urandom_range(0, 2) != 0);
      lsync = 1'b0;
      if (lvalid) begin
        lsync = (beat == 0);
        lx_re = DW'(xr[beat]); lx_im = DW'(xi[beat]);
        model_push(0, 64, beat);
        model_push(1, 16, beat);
        beat++;
      end
      @(posedge clk);
      #1;
      chk_long(0, v64, s64, int'(r64), int'(i64));
      chk_long(1, v16, s16, int'(r16), int'(i16));
    end
    lvalid = 1'b0; lsync = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_long(0, v64, s64, int'(r64), int'(i64));
      chk_long(1, v16, s16, int'(r16), int'(i16));
    end
    chk("L64 output count", rd[0], wr[0]);
    chk("L16 output count", rd[1], wr[1]);
    chk("L64 expected count", wr[0], NLONG - 64);
    chk("L16 expected count", wr[1], NLONG - 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
